// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : wb_pkg
//  Description : Shared types and helpers for the LEGv8 writeback stage:
//                load-size encoding, zero-register constant, the write
//                request record and the load-data extension function.
//  Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

   // Architectural zero register; writes to it are discarded.
   localparam logic [4:0] XZR = 5'd31;

   // Core-wide widths used by the packaged record types.
   localparam int WB_DATA_W = 64;
   localparam int WB_ADDR_W = 5;

   typedef enum logic [1:0] {
      SZ_B = 2'b00,
      SZ_H = 2'b01,
      SZ_W = 2'b10,
      SZ_D = 2'b11
   } mem_size_t;

   typedef struct packed {
      logic                 valid;
      logic [WB_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0] data;
   } wb_req_t;

   // Extend LSB-aligned load data to full width; dword passes through
   // regardless of the signed flag.
   function automatic logic [WB_DATA_W-1:0] load_ext(
      input logic [WB_DATA_W-1:0] raw,
      input mem_size_t            size,
      input logic                 sgn
   );
      logic [WB_DATA_W-1:0] r;
      case (size)
         SZ_B:    r = sgn ? {{56{raw[7]}},  raw[7:0]}  : {56'd0, raw[7:0]};
         SZ_H:    r = sgn ? {{48{raw[15]}}, raw[15:0]} : {48'd0, raw[15:0]};
         SZ_W:    r = sgn ? {{32{raw[31]}}, raw[31:0]} : {32'd0, raw[31:0]};
         default: r = raw;
      endcase
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/wb_late_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : wb_late_fifo
//  Description : In-order FIFO for late (multi-cycle) results. Each entry
//                carries a valid bit that can be cleared by a matching
//                destination register (WAW kill). Entries targeting XZR are
//                stored already invalid so they drain without a write.
//  Ports       : clk, reset          - clock, sync active-high reset
//                push/push_rd/_data  - enqueue (caller guarantees not full)
//                pop                 - dequeue head (caller guarantees not empty)
//                inv_en/inv_rd       - clear valid on entries with rd==inv_rd
//                head_valid/rd/data  - head entry contents
//                count               - occupied entries
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_late_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = 64,
   parameter int ADDR_W = 5,
   parameter int CNT_W  = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push,
   input  logic [ADDR_W-1:0] push_rd,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   input  logic              inv_en,
   input  logic [ADDR_W-1:0] inv_rd,
   output logic              head_valid,
   output logic [ADDR_W-1:0] head_rd,
   output logic [DATA_W-1:0] head_data,
   output logic [CNT_W-1:0]  count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic              r_vld  [DEPTH];
   logic [ADDR_W-1:0] r_rd   [DEPTH];
   logic [DATA_W-1:0] r_data [DEPTH];
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_vld[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            // The slot being written this edge holds a result accepted now,
            // so it is never killed by a same-cycle pipeline write.
            if (push && (r_tail == PTR_W'(i))) begin
               r_vld[i]  <= (push_rd != ADDR_W'(XZR));
               r_rd[i]   <= push_rd;
               r_data[i] <= push_data;
            end else if (inv_en && (r_rd[i] == inv_rd)) begin
               r_vld[i] <= 1'b0;
            end
         end
         if (push) r_tail <= ptr_inc(r_tail);
         if (pop)  r_head <= ptr_inc(r_head);
         case ({push, pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign head_valid = r_vld[r_head];
   assign head_rd    = r_rd[r_head];
   assign head_data  = r_data[r_head];
   assign count      = r_count;

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : Writeback stage. Holds the MEM/WB register, extends load
//                data, and arbitrates the register-file write port between
//                in-order pipeline results (always first) and a FIFO of late
//                MUL/DIV results.
//  Ports       : clk, reset                     - clock, sync active-high reset
//                mem_*_i                        - MEM stage results
//                lr_valid_i/lr_ready_o/lr_rd_i/lr_data_i - late result handshake
//                we3/wa3/wd3                    - register-file write port
//                buf_count_o                    - late buffer occupancy
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
   import wb_pkg::*;
#(
   parameter int DATA_W    = 64,
   parameter int ADDR_W    = 5,
   parameter int BUF_DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           mem_valid_i,
   input  logic                           mem_regwrite_i,
   input  logic                           mem_memtoreg_i,
   input  logic [ADDR_W-1:0]              mem_rd_i,
   input  logic [DATA_W-1:0]              mem_alu_result_i,
   input  logic [DATA_W-1:0]              mem_read_data_i,
   input  logic [1:0]                     mem_size_i,
   input  logic                           mem_signed_i,
   input  logic                           lr_valid_i,
   output logic                           lr_ready_o,
   input  logic [ADDR_W-1:0]              lr_rd_i,
   input  logic [DATA_W-1:0]              lr_data_i,
   output logic                           we3,
   output logic [ADDR_W-1:0]              wa3,
   output logic [DATA_W-1:0]              wd3,
   output logic [$clog2(BUF_DEPTH+1)-1:0] buf_count_o
);

   localparam int CNT_W = $clog2(BUF_DEPTH + 1);

   // MEM/WB register
   logic              r_pipe_vld;
   logic              r_memtoreg;
   logic [ADDR_W-1:0] r_rd;
   logic [DATA_W-1:0] r_alu;
   logic [DATA_W-1:0] r_rdata;
   logic [1:0]        r_size;
   logic              r_signed;

   // Last driven write address/data, held while no write occurs
   logic [ADDR_W-1:0] r_wa_hold;
   logic [DATA_W-1:0] r_wd_hold;

   logic              w_head_valid;
   logic [ADDR_W-1:0] w_head_rd;
   logic [DATA_W-1:0] w_head_data;
   logic [CNT_W-1:0]  w_count;
   logic              w_push;
   logic              w_pop;
   logic              w_pipe_we;
   wb_req_t           w_sel;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_pipe_vld <= 1'b0;
      end else begin
         r_pipe_vld <= mem_valid_i && mem_regwrite_i && (mem_rd_i != ADDR_W'(XZR));
      end
      r_memtoreg <= mem_memtoreg_i;
      r_rd       <= mem_rd_i;
      r_alu      <= mem_alu_result_i;
      r_rdata    <= mem_read_data_i;
      r_size     <= mem_size_i;
      r_signed   <= mem_signed_i;
   end

   // Pipeline result wins; otherwise the head drains. A killed head still
   // pops, costing a cycle with no write.
   always_comb begin
      w_sel     = '0;
      w_pipe_we = !reset && r_pipe_vld;
      w_pop     = !reset && !r_pipe_vld && (w_count != '0);
      if (w_pipe_we) begin
         w_sel.valid = 1'b1;
         w_sel.rd    = WB_ADDR_W'(r_rd);
         w_sel.data  = r_memtoreg
                       ? load_ext(WB_DATA_W'(r_rdata), mem_size_t'(r_size), r_signed)
                       : WB_DATA_W'(r_alu);
      end else if (w_pop) begin
         w_sel.valid = w_head_valid;
         w_sel.rd    = WB_ADDR_W'(w_head_rd);
         w_sel.data  = WB_DATA_W'(w_head_data);
      end
   end

   // Full buffer never passes a result through, even when popping.
   assign lr_ready_o  = !reset && (w_count < CNT_W'(BUF_DEPTH));
   assign w_push      = lr_valid_i && lr_ready_o;
   assign buf_count_o = reset ? '0 : w_count;

   assign we3 = w_sel.valid;
   assign wa3 = reset ? ADDR_W'(XZR) : (w_sel.valid ? ADDR_W'(w_sel.rd)   : r_wa_hold);
   assign wd3 = reset ? '0           : (w_sel.valid ? DATA_W'(w_sel.data) : r_wd_hold);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wa_hold <= ADDR_W'(XZR);
         r_wd_hold <= '0;
      end else if (w_sel.valid) begin
         r_wa_hold <= wa3;
         r_wd_hold <= wd3;
      end
   end

   wb_late_fifo #(
      .DEPTH  (BUF_DEPTH),
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .CNT_W  (CNT_W)
   ) u_late_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (w_push),
      .push_rd    (lr_rd_i),
      .push_data  (lr_data_i),
      .pop        (w_pop),
      .inv_en     (w_pipe_we),
      .inv_rd     (r_rd),
      .head_valid (w_head_valid),
      .head_rd    (w_head_rd),
      .head_data  (w_head_data),
      .count      (w_count)
   );

endmodule
`default_nettype wire
